// File: rtl/hazard_controller.sv
// hazard_controller: ID-stage hazard detection, stall/flush control and
// optional operand forwarding for a 5-stage pipeline.
// Optional feature macro: HAZARD_FORWARDING_EN. When it is defined, operands
// are forwarded from EX/MEM/WB and only load-use stalls. When it is undefined,
// no forwarding is done and any in-flight producer stalls ID.

// Matches one ID source register against the EX, MEM and WB destinations.
// m = {wb, mem, ex}. Register 0 never matches.
module hazard_src (
  input  logic [4:0] r,
  input  logic       src_use,
  input  logic [4:0] rd_ex,
  input  logic       le_ex,
  input  logic [4:0] rd_mem,
  input  logic       le_mem,
  input  logic [4:0] rd_wb,
  input  logic       le_wb,
  output logic [2:0] m
);
  logic live;
  assign live = src_use && (r != 5'd0);
  assign m[0] = live && le_ex  && (rd_ex  == r);
  assign m[1] = live && le_mem && (rd_mem == r);
  assign m[2] = live && le_wb  && (rd_wb  == r);
endmodule

module hazard_controller (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [4:0] RA_ID,
  input  logic [4:0] RB_ID,
  input  logic       RA_USE_ID,
  input  logic       RB_USE_ID,
  input  logic [4:0] RD_EX,
  input  logic       RF_LE_EX,
  input  logic       L_EX,
  input  logic [4:0] RD_MEM,
  input  logic       RF_LE_MEM,
  input  logic [4:0] RD_WB,
  input  logic       RF_LE_WB,
  input  logic       BR_TAKEN_EX,
  output logic       LE,
  output logic       S,
  output logic       IF_FLUSH,
  output logic [1:0] FWD_A,
  output logic [1:0] FWD_B,
  output logic [1:0] STATE,
  output logic [7:0] STALL_CNT
);
  localparam int NUM_SRC = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [NUM_SRC-1:0][4:0] src_r;
  logic [NUM_SRC-1:0]      src_use;
  logic [NUM_SRC-1:0][2:0] m;
  logic [NUM_SRC-1:0][1:0] fwd_sel;
  logic                    ld_use;
  logic                    hazard;

  assign src_r   = {RB_ID, RA_ID};
  assign src_use = {RB_USE_ID, RA_USE_ID};

  generate
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      hazard_src u_src (
        .r      (src_r[g]),
        .src_use(src_use[g]),
        .rd_ex  (RD_EX),
        .le_ex  (RF_LE_EX),
        .rd_mem (RD_MEM),
        .le_mem (RF_LE_MEM),
        .rd_wb  (RD_WB),
        .le_wb  (RF_LE_WB),
        .m      (m[g])
      );
    end
  endgenerate

  // A load in EX cannot be forwarded in time for either build.
  assign ld_use = (m[0][0] | m[1][0]) & L_EX;

`ifdef HAZARD_FORWARDING_EN
  assign hazard = ld_use;

  // Per-source forward select: youngest producer wins (EX > MEM > WB).
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (m[i][0])      fwd_sel[i] = 2'b01;
      else if (m[i][1]) fwd_sel[i] = 2'b10;
      else if (m[i][2]) fwd_sel[i] = 2'b11;
    end
  end
`else
  // Without forwarding any in-flight producer blocks ID until it retires.
  assign hazard  = ld_use | (|m);
  assign fwd_sel = '0;
`endif

  // Control outputs and next state; reset forces the safe bubble/hold values.
  always_comb begin
    LE       = 1'b1;
    S        = 1'b0;
    IF_FLUSH = 1'b0;
    FWD_A    = 2'b00;
    FWD_B    = 2'b00;
    state_d  = ST_RUN;
    if (!Rst) begin
      LE = 1'b0;
      S  = 1'b1;
    end else if (state_q == ST_FLUSH) begin
      // Slot after a redirect: ID holds a flushed bubble, nothing to check.
      state_d = ST_RUN;
    end else if (BR_TAKEN_EX) begin
      S        = 1'b1;
      IF_FLUSH = 1'b1;
      state_d  = ST_FLUSH;
    end else if (hazard) begin
      LE      = 1'b0;
      S       = 1'b1;
      state_d = ST_STALL;
    end else begin
      FWD_A = fwd_sel[0];
      FWD_B = fwd_sel[1];
    end
  end

  // State register; an illegal 2'b11 falls into the RUN path above.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // Saturating count of cycles the front end was held.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                           STALL_CNT <= 8'd0;
    else if (!LE && STALL_CNT != 8'hFF) STALL_CNT <= STALL_CNT + 8'd1;
  end

  assign STATE = state_q;
endmodule
